// File: rtl/prco_decode_stage_if.sv
// Fetch-side and downstream handshake bundle of the PRCO decode stage.
// The master modport is the environment (fetch + consumer); the slave modport is the stage itself.
interface prco_decode_stage_if #(
    parameter int INSTR_W = 16,
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 2
);
    logic               i_valid;
    logic               q_ready;
    logic [INSTR_W-1:0] i_instr;
    logic               i_flush;
    logic               q_valid;
    logic               i_ready;
    logic [4:0]         q_op;
    logic [2:0]         q_seld;
    logic [2:0]         q_sela;
    logic [2:0]         q_selb;
    logic               q_third_sel;
    logic [DATA_W-1:0]  q_imm;
    logic [DATA_W-1:0]  q_simm;
    logic               q_reg_we;
    logic               q_req_alu;
    logic               q_req_ram;
    logic               q_req_ram_we;
    logic               q_new_uart1_data;
    logic               q_illegal;
    logic [CNT_W-1:0]   q_count;

    modport master (
        output i_valid, i_instr, i_flush, i_ready,
        input  q_ready, q_valid, q_op, q_seld, q_sela, q_selb, q_third_sel,
               q_imm, q_simm, q_reg_we, q_req_alu, q_req_ram, q_req_ram_we,
               q_new_uart1_data, q_illegal, q_count
    );

    modport slave (
        input  i_valid, i_instr, i_flush, i_ready,
        output q_ready, q_valid, q_op, q_seld, q_sela, q_selb, q_third_sel,
               q_imm, q_simm, q_reg_we, q_req_alu, q_req_ram, q_req_ram_we,
               q_new_uart1_data, q_illegal, q_count
    );
endinterface

// File: rtl/prco_decode_stage.sv
// PRCO instruction decoder: decodes accepted instructions into bundles held in a
// DEPTH-entry buffer, presented downstream through a valid/ready handshake.
module prco_decode_stage #(
    parameter int INSTR_W = 16,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    prco_decode_stage_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [4:0] OP_NOP   = 5'd0;
    localparam logic [4:0] OP_MOV   = 5'd1;
    localparam logic [4:0] OP_MOVI  = 5'd2;
    localparam logic [4:0] OP_ADD   = 5'd3;
    localparam logic [4:0] OP_ADDI  = 5'd4;
    localparam logic [4:0] OP_CMP   = 5'd5;
    localparam logic [4:0] OP_JMP   = 5'd6;
    localparam logic [4:0] OP_LW    = 5'd7;
    localparam logic [4:0] OP_SW    = 5'd8;
    localparam logic [4:0] OP_WRITE = 5'd9;

    typedef struct packed {
        logic [4:0]        op;
        logic [2:0]        seld;
        logic [2:0]        sela;
        logic [2:0]        selb;
        logic              third_sel;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] simm;
        logic              reg_we;
        logic              req_alu;
        logic              req_ram;
        logic              req_ram_we;
        logic              uart;
        logic              illegal;
    } bundle_t;

    bundle_t          mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    bundle_t          dec;
    bundle_t          head;
    logic             full;
    logic             ready_int;
    logic             valid_int;
    logic             push;
    logic             pop;

    assign full      = (count_reg == CNT_W'(DEPTH));
    assign ready_int = !full && i_reset_n;
    assign valid_int = (count_reg != '0);
    // Flush wins over both sides of the handshake.
    assign push      = bus.i_valid && ready_int && !bus.i_flush;
    assign pop       = valid_int && bus.i_ready && !bus.i_flush;

    always_comb begin
        dec      = '0;
        dec.op   = bus.i_instr[INSTR_W-1 -: 5];
        dec.seld = bus.i_instr[10:8];
        dec.sela = bus.i_instr[7:5];
        dec.selb = bus.i_instr[4:2];
        dec.imm  = {{(DATA_W-8){1'b0}}, bus.i_instr[7:0]};
        dec.simm = {{(DATA_W-5){bus.i_instr[4]}}, bus.i_instr[4:0]};
        case (dec.op)
            OP_NOP: ;
            OP_MOV, OP_MOVI, OP_ADDI: begin
                dec.reg_we  = 1'b1;
                dec.req_alu = 1'b1;
            end
            OP_ADD: begin
                dec.reg_we    = 1'b1;
                dec.req_alu   = 1'b1;
                dec.third_sel = 1'b1;
            end
            OP_LW: begin
                dec.reg_we  = 1'b1;
                dec.req_ram = 1'b1;
                dec.req_alu = 1'b1;
            end
            OP_SW: begin
                dec.req_ram    = 1'b1;
                dec.req_ram_we = 1'b1;
                dec.req_alu    = 1'b1;
            end
            OP_CMP: begin
                dec.req_alu   = 1'b1;
                dec.third_sel = 1'b1;
            end
            OP_JMP:   dec.reg_we = 1'b1;
            OP_WRITE: dec.uart   = 1'b1;
            default:  dec.illegal = 1'b1;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n || bus.i_flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
        end
    end

    // Storage is cleared on reset so every bundle output reads zero afterwards.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else if (push) begin
            mem_reg[wr_ptr_reg] <= dec;
        end
    end

    assign head = mem_reg[rd_ptr_reg];

    assign bus.q_ready          = ready_int;
    assign bus.q_valid          = valid_int;
    assign bus.q_count          = count_reg;
    assign bus.q_op             = head.op;
    assign bus.q_seld           = head.seld;
    assign bus.q_sela           = head.sela;
    assign bus.q_selb           = head.selb;
    assign bus.q_third_sel      = head.third_sel;
    assign bus.q_imm            = head.imm;
    assign bus.q_simm           = head.simm;
    assign bus.q_reg_we         = head.reg_we;
    assign bus.q_req_alu        = head.req_alu;
    assign bus.q_req_ram        = head.req_ram;
    assign bus.q_req_ram_we     = head.req_ram_we;
    assign bus.q_new_uart1_data = head.uart;
    assign bus.q_illegal        = head.illegal;
endmodule

// File: tb/tb_prco_decode_stage.sv
// Directed, table-driven bench for prco_decode_stage: decode vectors plus
// backpressure, streaming, flush and mid-stream reset sequences.
module tb_prco_decode_stage;
    localparam int INSTR_W = 16;
    localparam int DATA_W  = 16;
    localparam int DEPTH   = 2;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic i_clk = 1'b0;
    logic i_reset_n;
    always #5 i_clk = ~i_clk;

    prco_decode_stage_if #(.INSTR_W(INSTR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    prco_decode_stage #(
        .INSTR_W(INSTR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .bus      (bus.slave)
    );

    typedef struct {
        logic [15:0] instr;
        logic [4:0]  op;
        logic [2:0]  seld, sela, selb;
        logic        third;
        logic [15:0] imm, simm;
        logic [4:0]  flags;    // {reg_we, alu, ram, ram_we, uart}
        logic        illegal;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [4:0] op, input logic [2:0] seld,
                            input logic [15:0] imm);
        chk({tag, " q_valid"}, 32'(bus.q_valid), 32'd1);
        chk({tag, " q_op"},    32'(bus.q_op),    32'(op));
        chk({tag, " q_seld"},  32'(bus.q_seld),  32'(seld));
        chk({tag, " q_imm"},   32'(bus.q_imm),   32'(imm));
    endtask

    initial begin
        //          instr    op     seld  sela  selb  3rd imm      simm     flags     ill
        vecs[0]  = '{16'h135A, 5'd2, 3'd3, 3'd2, 3'd6, 0, 16'h005A, 16'hFFFA, 5'b11000, 0}; // MOVI
        vecs[1]  = '{16'h3A36, 5'd7, 3'd2, 3'd1, 3'd5, 0, 16'h0036, 16'hFFF6, 5'b11100, 0}; // LW
        vecs[2]  = '{16'h194C, 5'd3, 3'd1, 3'd2, 3'd3, 1, 16'h004C, 16'h000C, 5'b11000, 0}; // ADD
        vecs[3]  = '{16'h40BF, 5'd8, 3'd0, 3'd5, 3'd7, 0, 16'h00BF, 16'hFFFF, 5'b01110, 0}; // SW
        vecs[4]  = '{16'h2F04, 5'd5, 3'd7, 3'd0, 3'd1, 1, 16'h0004, 16'h0004, 5'b01000, 0}; // CMP
        vecs[5]  = '{16'h3410, 5'd6, 3'd4, 3'd0, 3'd4, 0, 16'h0010, 16'hFFF0, 5'b10000, 0}; // JMP
        vecs[6]  = '{16'h48E1, 5'd9, 3'd0, 3'd7, 3'd0, 0, 16'h00E1, 16'h0001, 5'b00001, 0}; // WRITE
        vecs[7]  = '{16'h0000, 5'd0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, 16'h0000, 5'b00000, 0}; // NOP
        vecs[8]  = '{16'h0DC0, 5'd1, 3'd5, 3'd6, 3'd0, 0, 16'h00C0, 16'h0000, 5'b11000, 0}; // MOV
        vecs[9]  = '{16'h267F, 5'd4, 3'd6, 3'd3, 3'd7, 0, 16'h007F, 16'hFFFF, 5'b11000, 0}; // ADDI
        vecs[10] = '{16'hFF12, 5'd31, 3'd7, 3'd0, 3'd4, 0, 16'h0012, 16'hFFF2, 5'b00000, 1}; // undefined

        i_reset_n   = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_instr = '0;
        bus.i_flush = 1'b0;
        bus.i_ready = 1'b0;
        repeat (3) step();
        chk("reset q_ready", 32'(bus.q_ready), 32'd0);
        chk("reset q_valid", 32'(bus.q_valid), 32'd0);
        chk("reset q_count", 32'(bus.q_count), 32'd0);
        chk("reset q_op",    32'(bus.q_op),    32'd0);
        chk("reset q_imm",   32'(bus.q_imm),   32'd0);
        i_reset_n = 1'b1;
        step();
        chk("release q_ready", 32'(bus.q_ready), 32'd1);
        chk("release q_valid", 32'(bus.q_valid), 32'd0);

        // Decode table: each vector is pushed into an empty buffer, checked, then popped.
        for (int i = 0; i < 11; i++) begin
            bus.i_valid = 1'b1;
            bus.i_instr = vecs[i].instr;
            step();
            bus.i_valid = 1'b0;
            $display("vec %0d: instr %h -> op %0d count %0d", i, vecs[i].instr, bus.q_op, bus.q_count);
            chk($sformatf("vec%0d q_valid", i), 32'(bus.q_valid), 32'd1);
            chk($sformatf("vec%0d q_count", i), 32'(bus.q_count), 32'd1);
            chk($sformatf("vec%0d q_op", i),    32'(bus.q_op),    32'(vecs[i].op));
            chk($sformatf("vec%0d q_seld", i),  32'(bus.q_seld),  32'(vecs[i].seld));
            chk($sformatf("vec%0d q_sela", i),  32'(bus.q_sela),  32'(vecs[i].sela));
            chk($sformatf("vec%0d q_selb", i),  32'(bus.q_selb),  32'(vecs[i].selb));
            chk($sformatf("vec%0d q_third_sel", i), 32'(bus.q_third_sel), 32'(vecs[i].third));
            chk($sformatf("vec%0d q_imm", i),   32'(bus.q_imm),   32'(vecs[i].imm));
            chk($sformatf("vec%0d q_simm", i),  32'(bus.q_simm),  32'(vecs[i].simm));
            chk($sformatf("vec%0d flags", i),
                32'({bus.q_reg_we, bus.q_req_alu, bus.q_req_ram, bus.q_req_ram_we, bus.q_new_uart1_data}),
                32'(vecs[i].flags));
            chk($sformatf("vec%0d q_illegal", i), 32'(bus.q_illegal), 32'(vecs[i].illegal));
            bus.i_ready = 1'b1;
            step();
            bus.i_ready = 1'b0;
            chk($sformatf("vec%0d popped q_valid", i), 32'(bus.q_valid), 32'd0);
        end

        // Backpressure: MOVI A/B/C with Rd 1/2/3, i_ready held low.
        bus.i_valid = 1'b1; bus.i_instr = 16'h1111; step();
        bus.i_instr = 16'h1222; step();
        $display("bp: two pushed, count %0d ready %0d", bus.q_count, bus.q_ready);
        chk("bp full count", 32'(bus.q_count), 32'd2);
        chk("bp full ready", 32'(bus.q_ready), 32'd0);
        bus.i_instr = 16'h1333; step();
        chk("bp wait count", 32'(bus.q_count), 32'd2);
        chk("bp wait ready", 32'(bus.q_ready), 32'd0);
        chk_head("bp head A", 5'd2, 3'd1, 16'h0011);
        bus.i_ready = 1'b1; step();
        bus.i_ready = 1'b0;
        $display("bp: one pop while full, count %0d ready %0d", bus.q_count, bus.q_ready);
        chk("bp pop count", 32'(bus.q_count), 32'd1);
        chk("bp pop ready", 32'(bus.q_ready), 32'd1);
        chk_head("bp head B", 5'd2, 3'd2, 16'h0022);
        step();
        bus.i_valid = 1'b0;
        chk("bp C accepted count", 32'(bus.q_count), 32'd2);
        chk_head("bp head B still", 5'd2, 3'd2, 16'h0022);
        bus.i_ready = 1'b1; step();
        chk_head("bp head C", 5'd2, 3'd3, 16'h0033);
        chk("bp drain count", 32'(bus.q_count), 32'd1);
        step();
        bus.i_ready = 1'b0;
        chk("bp empty count", 32'(bus.q_count), 32'd0);
        chk("bp empty valid", 32'(bus.q_valid), 32'd0);

        // Streaming: 8 MOVIs with Rd=k, imm=k*0x11, one bundle per cycle.
        bus.i_ready = 1'b1;
        bus.i_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.i_instr = {5'd2, 3'(k), 8'(k * 17)};
            step();
            $display("stream %0d: op %0d seld %0d imm %h count %0d", k, bus.q_op, bus.q_seld, bus.q_imm, bus.q_count);
            chk_head($sformatf("stream%0d", k), 5'd2, 3'(k), 16'(k * 17));
            chk($sformatf("stream%0d count", k), 32'(bus.q_count), 32'd1);
        end
        bus.i_valid = 1'b0;
        step();
        bus.i_ready = 1'b0;
        chk("stream end count", 32'(bus.q_count), 32'd0);

        // Flush with two bundles buffered and an ADD presented in the same cycle.
        bus.i_valid = 1'b1; bus.i_instr = 16'h1111; step();
        bus.i_instr = 16'h1222; step();
        bus.i_instr = 16'h194C; bus.i_flush = 1'b1; step();
        bus.i_flush = 1'b0; bus.i_valid = 1'b0;
        $display("flush: count %0d valid %0d ready %0d", bus.q_count, bus.q_valid, bus.q_ready);
        chk("flush count", 32'(bus.q_count), 32'd0);
        chk("flush valid", 32'(bus.q_valid), 32'd0);
        chk("flush ready", 32'(bus.q_ready), 32'd1);
        step();
        chk("flush dropped count", 32'(bus.q_count), 32'd0);
        bus.i_valid = 1'b1; bus.i_instr = 16'h1544; step();
        bus.i_valid = 1'b0;
        chk_head("after flush head", 5'd2, 3'd5, 16'h0044);
        chk("after flush count", 32'(bus.q_count), 32'd1);

        // Mid-stream reset with bundles queued.
        bus.i_valid = 1'b1; bus.i_instr = 16'h1666; step();
        bus.i_valid = 1'b0;
        chk("pre-reset count", 32'(bus.q_count), 32'd2);
        i_reset_n = 1'b0; step();
        $display("midreset: count %0d valid %0d ready %0d", bus.q_count, bus.q_valid, bus.q_ready);
        chk("midreset count", 32'(bus.q_count), 32'd0);
        chk("midreset valid", 32'(bus.q_valid), 32'd0);
        chk("midreset ready", 32'(bus.q_ready), 32'd0);
        chk("midreset q_op",  32'(bus.q_op),    32'd0);
        i_reset_n = 1'b1; step();
        chk("post-reset ready", 32'(bus.q_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
